// File: rtl/cmt_prog_ctrl_if.sv
// ---------------------------------------------------------------------------
// cmt_prog_ctrl_if
//   Request handshake between the host register file and the programmable
//   application clock sequencer (cmt_prog_ctrl).
//
//   req_valid  host -> seq   new M/D request present
//   req_m      host -> seq   requested CLKFX_MULTIPLY (2..255)
//   req_d      host -> seq   requested CLKFX_DIVIDE (1..255)
//   req_ready  seq  -> host  sequencer idle, request will be taken this edge
//
//   master : host side (drives the request)
//   slave  : sequencer side (drives ready)
// ---------------------------------------------------------------------------
interface cmt_prog_ctrl_if;
    logic       req_valid;
    logic [7:0] req_m;
    logic [7:0] req_d;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_m,
        output req_d,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_m,
        input  req_d,
        output req_ready
    );
endinterface

// File: rtl/cmt_prog_ctrl.sv
// ---------------------------------------------------------------------------
// cmt_prog_ctrl
//   Sequencer for the programmable application clock
//   (DCM_CLKGEN -> PLL -> BUFGCE), clocked on the DCM PROGCLK domain.
//   Takes an M/D request, range-checks the resulting PLL input frequency,
//   shifts LoadD / LoadM / Go into the DCM, waits for PROGDONE and finally
//   pulses the PLL reset.
//
//   clk           PROGCLK, rising edge
//   reset         synchronous, active-high
//   req           request handshake (slave side of cmt_prog_ctrl_if)
//   progen        DCM PROGEN   (registered)
//   progdata      DCM PROGDATA (registered)
//   progdone_inv  low = DCM programming complete
//   pll_reset     PLL reset    (registered)
//   busy          sequencer not idle
//   done          one-cycle pulse on successful completion
//   err           sticky error, cleared by the next accepted request
//   cur_m, cur_d  last successfully programmed M/D
// ---------------------------------------------------------------------------
module cmt_prog_ctrl #(
    parameter int FREQ_IN        = 48,
    parameter int FIN_MIN        = 21,
    parameter int FIN_MAX        = 56,
    parameter int M_INIT         = 20,
    parameter int D_INIT         = 27,
    parameter int TIMEOUT        = 4096,
    parameter int PLL_RST_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    cmt_prog_ctrl_if.slave        req,
    output logic                  progen,
    output logic                  progdata,
    input  logic                  progdone_inv,
    output logic                  pll_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [7:0]            cur_m,
    output logic [7:0]            cur_d
);

    // One shared counter: bit index, PROGDONE timeout and PLL reset length.
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [CW-1:0] LAST_BIT = CW'(9);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] PLL_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] IGNORE_N = CW'(2);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_REJECT    = 4'd1;
    localparam logic [3:0] S_LOAD_D    = 4'd2;
    localparam logic [3:0] S_GAP1      = 4'd3;
    localparam logic [3:0] S_LOAD_M    = 4'd4;
    localparam logic [3:0] S_GAP2      = 4'd5;
    localparam logic [3:0] S_GO        = 4'd6;
    localparam logic [3:0] S_WAIT_DONE = 4'd7;
    localparam logic [3:0] S_PLL_RST   = 4'd8;

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    m_q, m_d, d_q, d_d;
    logic [7:0]    cur_m_q, cur_m_d, cur_d_q, cur_d_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          progen_q, progen_d;
    logic          progdata_q, progdata_d;
    logic          pll_reset_q, pll_reset_d;

    // Range check: FIN_MIN*d <= FREQ_IN*m <= FIN_MAX*d, all in 16 bits.
    logic [15:0] prod_m, lim_lo, lim_hi;
    logic        req_ok;

    assign prod_m = 16'(FREQ_IN) * {8'd0, req.req_m};
    assign lim_lo = 16'(FIN_MIN) * {8'd0, req.req_d};
    assign lim_hi = 16'(FIN_MAX) * {8'd0, req.req_d};
    assign req_ok = (req.req_m >= 8'd2) && (req.req_d != 8'd0) &&
                    (prod_m >= lim_lo) && (prod_m <= lim_hi);

    // The DCM expects (value - 1), shifted LSB first after the 2-bit opcode.
    logic [7:0] d_minus1, m_minus1;
    logic [2:0] payload_idx;

    assign d_minus1    = d_q - 8'd1;
    assign m_minus1    = m_q - 8'd1;
    assign payload_idx = 3'(cnt_q - CW'(2));

    always_comb begin
        // NOTE: every variable gets its default before the case, so no path
        // can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        m_d         = m_q;
        d_d         = d_q;
        ok_d        = ok_q;
        err_d       = err_q;
        cur_m_d     = cur_m_q;
        cur_d_d     = cur_d_q;
        done_d      = 1'b0;
        progen_d    = 1'b0;
        progdata_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req.req_valid) begin
                    m_d   = req.req_m;
                    d_d   = req.req_d;
                    cnt_d = '0;
                    ok_d  = 1'b0;
                    err_d = !req_ok;
                    state_d = req_ok ? S_LOAD_D : S_REJECT;
                end
            end
            S_REJECT: state_d = S_IDLE;
            S_LOAD_D: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = S_GAP1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP1: state_d = S_LOAD_M;
            S_LOAD_M: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = S_GAP2;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP2: state_d = S_GO;
            S_GO: begin
                state_d = S_WAIT_DONE;
                cnt_d   = '0;
            end
            S_WAIT_DONE: begin
                // PROGDONE from the previous load may still be asserted for
                // the first two cycles, so it is not trusted until then.
                if (cnt_q >= IGNORE_N && !progdone_inv) begin
                    ok_d    = 1'b1;
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PLL_RST: begin
                if (cnt_q == PLL_LAST) begin
                    state_d = S_IDLE;
                    if (ok_q) begin
                        cur_m_d = m_q;
                        cur_d_d = d_q;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // PROG pins follow the current state one cycle later, so the first
        // PROGEN appears one edge after the accept.
        case (state_q)
            S_LOAD_D: begin
                progen_d   = 1'b1;
                progdata_d = (cnt_q == '0) ? 1'b1 :
                             (cnt_q == CW'(1)) ? 1'b0 : d_minus1[payload_idx];
            end
            S_LOAD_M: begin
                progen_d   = 1'b1;
                progdata_d = (cnt_q < CW'(2)) ? 1'b1 : m_minus1[payload_idx];
            end
            S_GO:    progen_d = 1'b1;
            default: ;
        endcase

        pll_reset_d = (state_d == S_PLL_RST);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment only, so every
        // register samples the pre-edge value of the others.
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            m_q         <= '0;
            d_q         <= '0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            cur_m_q     <= 8'(M_INIT);
            cur_d_q     <= 8'(D_INIT);
            done_q      <= 1'b0;
            progen_q    <= 1'b0;
            progdata_q  <= 1'b0;
            pll_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            m_q         <= m_d;
            d_q         <= d_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            cur_m_q     <= cur_m_d;
            cur_d_q     <= cur_d_d;
            done_q      <= done_d;
            progen_q    <= progen_d;
            progdata_q  <= progdata_d;
            pll_reset_q <= pll_reset_d;
        end
    end

    assign req.req_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign progen        = progen_q;
    assign progdata      = progdata_q;
    assign pll_reset     = pll_reset_q;
    assign done          = done_q;
    assign err           = err_q;
    assign cur_m         = cur_m_q;
    assign cur_d         = cur_d_q;

endmodule

// File: tb/tb_cmt_prog_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cmt_prog_ctrl
//   Directed self-checking bench for cmt_prog_ctrl: reset state, full
//   programming sequences, range rejects, PROGDONE timeout, held request
//   and reset in the middle of LoadM.
// ---------------------------------------------------------------------------
module tb_cmt_prog_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       progen, progdata, progdone_inv, pll_reset;
    logic       busy, done, err;
    logic [7:0] cur_m, cur_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmt_prog_ctrl_if bus ();

    cmt_prog_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .req          (bus),
        .progen       (progen),
        .progdata     (progdata),
        .progdone_inv (progdone_inv),
        .pll_reset    (pll_reset),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .cur_m        (cur_m),
        .cur_d        (cur_d)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a request and check every PROG bit up to and including Go.
    task automatic start_req(input logic [7:0] m, input logic [7:0] d, input bit hold,
                             input string tag);
        logic [7:0] dm1, mm1;
        logic       b;
        dm1 = d - 8'd1;
        mm1 = m - 8'd1;
        bus.req_valid = 1'b1;
        bus.req_m     = m;
        bus.req_d     = d;
        tick();
        if (hold) begin
            bus.req_m = 8'hFF;
            bus.req_d = 8'h01;
        end else begin
            bus.req_valid = 1'b0;
        end
        check({tag, " accept"}, {progen, busy, bus.req_ready, err}, 4'b0100);
        for (int k = 0; k < 10; k++) begin
            tick();
            b = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : dm1[k-2];
            check($sformatf("%s loadd bit%0d", tag, k),
                  {progen, progdata, busy, bus.req_ready}, {1'b1, b, 2'b10});
        end
        tick();
        check({tag, " gap1"}, {progen, progdata, busy}, 3'b001);
        for (int k = 0; k < 10; k++) begin
            tick();
            b = (k < 2) ? 1'b1 : mm1[k-2];
            check($sformatf("%s loadm bit%0d", tag, k),
                  {progen, progdata, busy, bus.req_ready}, {1'b1, b, 2'b10});
        end
        tick();
        check({tag, " gap2"}, {progen, progdata, busy}, 3'b001);
        tick();
        check({tag, " go"}, {progen, progdata, pll_reset}, 3'b100);
    endtask

    // From just after the Go edge: drive PROGDONE, time the PLL reset pulse
    // and check the completion status.
    task automatic finish_req(input int drop_at, input bit stale, input int exp_rise,
                              input bit exp_ok, input logic [7:0] exp_m,
                              input logic [7:0] exp_d, input string tag);
        int rise = -1;
        int hi   = 0;
        int viol = 0;
        for (int j = 1; j <= 5000 && rise < 0; j++) begin
            if (stale && j == 1) progdone_inv = 1'b0;
            if (stale && j == 3) progdone_inv = 1'b1;
            if (j - 1 == drop_at) progdone_inv = 1'b0;
            tick();
            if (progen) viol++;
            if (pll_reset) rise = j;
        end
        bus.req_valid = 1'b0;
        check({tag, " pll_reset rise cycle"}, rise, exp_rise);
        check({tag, " err at pll_reset"}, err, !exp_ok);
        hi = (rise > 0) ? 1 : 0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (progen) viol++;
            if (!pll_reset) break;
            hi++;
        end
        progdone_inv = 1'b1;
        check({tag, " pll_reset length"}, hi, 16);
        check({tag, " progen quiet"}, viol, 0);
        check({tag, " done/busy/ready"}, {done, busy, bus.req_ready}, {exp_ok, 2'b01});
        check({tag, " cur_m"}, cur_m, exp_m);
        check({tag, " cur_d"}, cur_d, exp_d);
        tick();
        check({tag, " done single pulse"}, {done, busy}, 2'b00);
    endtask

    task automatic reject_req(input logic [7:0] m, input logic [7:0] d, input string tag);
        int viol = 0;
        bus.req_valid = 1'b1;
        bus.req_m     = m;
        bus.req_d     = d;
        tick();
        bus.req_valid = 1'b0;
        check({tag, " reject edge"}, {progen, busy, bus.req_ready, err}, 4'b0101);
        tick();
        check({tag, " back to idle"}, {progen, busy, bus.req_ready, err}, 4'b0011);
        for (int j = 0; j < 3; j++) begin
            tick();
            if (progen || pll_reset) viol++;
        end
        check({tag, " no prog activity"}, viol, 0);
        check({tag, " cur unchanged"}, {cur_m, cur_d}, {8'd38, 8'd42});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_m     = 8'd0;
        bus.req_d     = 8'd0;
        progdone_inv  = 1'b1;
        repeat (3) tick();
        check("reset outputs", {progen, progdata, pll_reset, busy, done, err, bus.req_ready},
              7'b0000001);
        check("reset cur", {cur_m, cur_d}, {8'd20, 8'd27});
        reset = 1'b0;
        tick();

        // m=20, d=27, PROGDONE 30 cycles after Go.
        start_req(8'd20, 8'd27, 1'b0, "m20d27");
        finish_req(30, 1'b0, 31, 1'b1, 8'd20, 8'd27, "m20d27");

        // d=0 rejected.
        bus.req_valid = 1'b1;
        bus.req_m     = 8'd20;
        bus.req_d     = 8'd0;
        tick();
        bus.req_valid = 1'b0;
        check("d0 reject edge", {progen, busy, bus.req_ready, err}, 4'b0101);
        tick();
        check("d0 back to idle", {progen, busy, bus.req_ready, err}, 4'b0011);

        // m=38, d=42 with req_valid held through the sequence and a stale
        // PROGDONE during the first cycles after Go; err clears on accept.
        start_req(8'd38, 8'd42, 1'b1, "m38d42");
        finish_req(10, 1'b1, 11, 1'b1, 8'd38, 8'd42, "m38d42");

        reject_req(8'd30, 8'd20, "m30d20");
        reject_req(8'd9,  8'd27, "m9d27");

        // PROGDONE never arrives.
        start_req(8'd40, 8'd50, 1'b0, "tmo");
        finish_req(-1, 1'b0, 4096, 1'b0, 8'd38, 8'd42, "tmo");
        check("tmo err sticky", err, 1'b1);

        // Reset during LoadM bit 5.
        bus.req_valid = 1'b1;
        bus.req_m     = 8'd38;
        bus.req_d     = 8'd42;
        tick();
        bus.req_valid = 1'b0;
        repeat (17) tick();
        check("rst loadm bit5", {progen, progdata, busy}, 3'b101);
        reset = 1'b1;
        tick();
        check("rst abort outputs", {progen, progdata, pll_reset, busy, done, err, bus.req_ready},
              7'b0000001);
        check("rst abort cur", {cur_m, cur_d}, {8'd20, 8'd27});
        reset = 1'b0;
        tick();
        check("rst stays idle", {progen, busy}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
